// File: rtl/bank_server.sv
`default_nettype none
// bank_server: single-port 256x16 memory bank behind a round-robin arbiter.
// Serves one core request at a time with a fixed access latency, then pulses a one-hot ack.
module bank_server #(
  parameter int         LATENCY = 2,
  parameter logic [3:0] BANK_ID = 4'd0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [3:0]   core_cnt,
  input  logic [15:0]  core_val,
  input  logic [15:0]  core_we,
  input  logic [191:0] bank_addr,
  input  logic [255:0] wr_data,
  output logic         core_serv,
  output logic [15:0]  core_ack,
  output logic [15:0]  rd_data,
  output logic [3:0]   bank_num
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  id_q, id_d;
  logic [3:0]  last_id_q, last_id_d;
  logic        skip_q, skip_d;
  logic        we_q, we_d;
  logic        serv_q, serv_d;
  logic [7:0]  word_q, word_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] ack_q, ack_d;
  logic [15:0] mem_q [256];

  logic [11:0] addr_arr [16];
  logic [15:0] data_arr [16];
  logic [11:0] sel_addr;
  logic        accept;
  logic        mem_wr;

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      addr_arr[i] = bank_addr[12*i +: 12];
      data_arr[i] = wr_data[16*i +: 16];
    end
  end

  assign sel_addr = addr_arr[core_cnt];
  // The skip term stops a core whose valid lingers one cycle past its ack from being served twice.
  assign accept   = core_val[core_cnt] && (sel_addr[11:8] == BANK_ID) &&
                    !(skip_q && (core_cnt == last_id_q));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    last_id_d = last_id_q;
    skip_d    = skip_q;
    we_d      = we_q;
    word_d    = word_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    serv_d    = 1'b0;
    ack_d     = 16'h0;
    mem_wr    = 1'b0;
    case (state_q)
      IDLE: begin
        skip_d = 1'b0;
        if (accept) begin
          id_d    = core_cnt;
          word_d  = sel_addr[7:0];
          we_d    = core_we[core_cnt];
          wdata_d = data_arr[core_cnt];
          cnt_d   = CNT_LOAD;
          serv_d  = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        serv_d = 1'b1;
        if (cnt_q == 4'd0) begin
          mem_wr = we_q;
          if (!we_q) rdata_d = mem_q[word_q];
          ack_d   = 16'(1) << id_q;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        last_id_d = id_q;
        skip_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      id_q      <= 4'd0;
      last_id_q <= 4'd0;
      skip_q    <= 1'b0;
      we_q      <= 1'b0;
      word_q    <= 8'h0;
      wdata_q   <= 16'h0;
      rdata_q   <= 16'h0;
      serv_q    <= 1'b0;
      ack_q     <= 16'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      last_id_q <= last_id_d;
      skip_q    <= skip_d;
      we_q      <= we_d;
      word_q    <= word_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      serv_q    <= serv_d;
      ack_q     <= ack_d;
    end
  end

  // Storage is not reset; a reset coinciding with the write edge suppresses the write.
  always_ff @(posedge clock) begin
    if (!reset && mem_wr) mem_q[word_q] <= wdata_q;
  end

  assign core_serv = serv_q;
  assign core_ack  = ack_q;
  assign rd_data   = rdata_q;
  assign bank_num  = BANK_ID;

endmodule
`default_nettype wire

// File: tb/tb_bank_server.sv
`default_nettype none
// tb_bank_server: two bank_server instances (LATENCY=2/bank 3 and LATENCY=1/bank 4) checked
// against a transaction-level memory model with directed and randomized requests.
module tb_bank_server;

  localparam int         LAT_A  = 2;
  localparam int         LAT_B  = 1;
  localparam logic [3:0] BANK_A = 4'd3;
  localparam logic [3:0] BANK_B = 4'd4;

  logic         clock = 1'b0;
  logic         reset;
  logic [3:0]   core_cnt;
  logic [15:0]  core_val;
  logic [15:0]  core_we;
  logic [191:0] bank_addr;
  logic [255:0] wr_data;
  logic         serv_a, serv_b;
  logic [15:0]  ack_a, ack_b, rd_a, rd_b;
  logic [3:0]   bnum_a, bnum_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] mem_m   [2][256];
  logic [15:0] last_rd [2];

  always #5 clock = ~clock;

  bank_server #(.LATENCY(LAT_A), .BANK_ID(BANK_A)) u_a (
    .clock(clock), .reset(reset), .core_cnt(core_cnt), .core_val(core_val),
    .core_we(core_we), .bank_addr(bank_addr), .wr_data(wr_data),
    .core_serv(serv_a), .core_ack(ack_a), .rd_data(rd_a), .bank_num(bnum_a)
  );

  bank_server #(.LATENCY(LAT_B), .BANK_ID(BANK_B)) u_b (
    .clock(clock), .reset(reset), .core_cnt(core_cnt), .core_val(core_val),
    .core_we(core_we), .bank_addr(bank_addr), .wr_data(wr_data),
    .core_serv(serv_b), .core_ack(ack_b), .rd_data(rd_b), .bank_num(bnum_b)
  );

  function automatic logic get_serv(input int d);
    return (d == 0) ? serv_a : serv_b;
  endfunction

  function automatic logic [15:0] get_ack(input int d);
    return (d == 0) ? ack_a : ack_b;
  endfunction

  function automatic logic [15:0] get_rd(input int d);
    return (d == 0) ? rd_a : rd_b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    core_cnt = 4'($urandom);
    core_we  = 16'($urandom);
    for (int i = 0; i < 6; i++) bank_addr[32*i +: 32] = $urandom;
    for (int i = 0; i < 8; i++) wr_data[32*i +: 32] = $urandom;
  endtask

  // One complete request to instance d; served core's inputs are scrambled after accept.
  task automatic run_req(input int d, input int core, input bit we,
                         input logic [7:0] word, input logic [15:0] data);
    int          lat;
    logic [3:0]  bank;
    logic [15:0] exp_rd;
    lat  = (d == 0) ? LAT_A : LAT_B;
    bank = (d == 0) ? BANK_A : BANK_B;
    core_val = 16'h0;
    @(negedge clock);
    check("idle_serv", get_serv(d), 32'd0);
    @(negedge clock);
    scramble();
    core_cnt = 4'(core);
    core_val = 16'(1) << core;
    core_we[core] = we;
    bank_addr[12*core +: 12] = {bank, word};
    wr_data[16*core +: 16] = data;
    exp_rd = we ? last_rd[d] : mem_m[d][word];
    if (we) mem_m[d][word] = data;
    else    last_rd[d] = exp_rd;
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clock);
      check("serv", get_serv(d), 32'd1);
      check("ack", get_ack(d), (k == lat + 1) ? 32'(16'(1) << core) : 32'd0);
      check("other_idle", {get_serv(1-d), get_ack(1-d)}, 32'd0);
      if (k == lat + 1) begin
        check("rd_data", get_rd(d), exp_rd);
        check("other_rd", get_rd(1-d), last_rd[1-d]);
      end
      scramble();
      core_val = 16'h0;
    end
  endtask

  initial begin
    reset = 1'b1; core_cnt = 4'd0; core_val = 16'h0; core_we = 16'h0;
    bank_addr = '0; wr_data = '0;
    last_rd[0] = 16'h0; last_rd[1] = 16'h0;
    repeat (3) @(negedge clock);
    check("rst_serv", {serv_a, serv_b}, 32'd0);
    check("rst_ack", {ack_a, ack_b}, 32'd0);
    check("rst_rd", {rd_a, rd_b}, 32'd0);
    check("rst_bank_num", {bnum_a, bnum_b}, {24'd0, BANK_A, BANK_B});
    reset = 1'b0;

    // Write then read back, both latencies, and extreme core indices.
    run_req(0, 5, 1'b1, 8'h10, 16'hBEEF);
    run_req(0, 5, 1'b0, 8'h10, 16'h0000);
    run_req(1, 3, 1'b1, 8'h55, 16'hA5A5);
    run_req(1, 3, 1'b0, 8'h55, 16'h0000);
    run_req(0, 0, 1'b1, 8'h01, 16'h1357);
    run_req(0, 15, 1'b0, 8'h01, 16'h0000);
    run_req(1, 15, 1'b1, 8'h02, 16'h2468);
    run_req(1, 0, 1'b0, 8'h02, 16'h0000);

    // Bank mismatch: selected, valid, but bank field 1 matches neither instance.
    core_val = 16'h0;
    @(negedge clock);
    core_cnt = 4'd2; core_val = 16'h0004; bank_addr[24 +: 12] = {4'h1, 8'h33};
    for (int n = 0; n < 6; n++) begin
      @(negedge clock);
      check("mismatch_serv", {serv_a, serv_b}, 32'd0);
      check("mismatch_ack", {ack_a, ack_b}, 32'd0);
    end
    core_val = 16'h0;

    // Skip rule: core 7 holds valid past its ack; re-accept only after the skip cycle.
    @(negedge clock);
    @(negedge clock);
    core_cnt = 4'd7; core_val = 16'h0080; core_we[7] = 1'b0;
    bank_addr[84 +: 12] = {BANK_A, 8'h10};
    last_rd[0] = mem_m[0][8'h10];
    for (int n = 1; n <= 8; n++) begin
      @(negedge clock);
      check("skip_serv", serv_a, ((n <= 3) || (n >= 6)) ? 32'd1 : 32'd0);
      check("skip_ack", ack_a, ((n == 3) || (n == 8)) ? 32'h0080 : 32'd0);
      if (n == 3 || n == 8) check("skip_rd", rd_a, last_rd[0]);
      if (n == 8) core_val = 16'h0;
    end

    // Reset during the first access cycle of a write must leave memory untouched.
    run_req(0, 4, 1'b1, 8'h20, 16'h1234);
    core_val = 16'h0;
    @(negedge clock);
    @(negedge clock);
    core_cnt = 4'd9; core_val = 16'h0200; core_we[9] = 1'b1;
    bank_addr[108 +: 12] = {BANK_A, 8'h20}; wr_data[144 +: 16] = 16'hDEAD;
    @(negedge clock);
    check("pre_reset_serv", serv_a, 32'd1);
    reset = 1'b1; core_val = 16'h0;
    @(negedge clock);
    reset = 1'b0;
    last_rd[0] = 16'h0; last_rd[1] = 16'h0;
    for (int n = 0; n < 4; n++) begin
      check("abort_serv", {serv_a, serv_b}, 32'd0);
      check("abort_ack", {ack_a, ack_b}, 32'd0);
      @(negedge clock);
    end
    check("abort_rd", {rd_a, rd_b}, 32'd0);
    run_req(0, 9, 1'b0, 8'h20, 16'h0000);

    // Randomized traffic over a small word window so reads hit written data.
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 8; w++)
        run_req(d, int'($urandom_range(0, 15)), 1'b1, 8'h80 + 8'(w), 16'($urandom));
    for (int n = 0; n < 40; n++)
      run_req(int'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 1'($urandom),
              8'h80 + 8'($urandom_range(0, 7)), 16'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bank_server.md
BANK_SERVER -- requirements
Module: bank_server

Interface
REQ-001 Parameter LATENCY, default 2: access cycles per request; legal range 1..15.
REQ-002 Parameter BANK_ID, default 4'd0: bank number this block serves.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 core_cnt  input  4  core index currently granted by the round-robin arbiter.
REQ-006 core_val  input  16  per-core request-valid; bit i belongs to core i.
REQ-007 core_we  input  16  per-core write enable: 1 = write, 0 = read.
REQ-008 bank_addr  input  192  per-core address, 12 bits per core; core i uses [12i+11:12i]; bank field [12i+11:12i+8]; word field [12i+7:12i].
REQ-009 wr_data  input  256  per-core write data, 16 bits per core at [16i+15:16i].
REQ-010 core_serv  output  1  busy flag to the arbiter; high holds the arbiter's core_cnt.
REQ-011 core_ack  output  16  one-hot, one-cycle completion pulse to the served core.
REQ-012 rd_data  output  16  read data of the most recently completed read.
REQ-013 bank_num  output  4  constant BANK_ID, driven to the arbiter's bank_num port.

Function
REQ-014 Storage: 256 x 16-bit words, indexed by the 8-bit word field; contents are not reset.
REQ-015 FSM states: IDLE, ACCESS, RESP; all outputs registered.
REQ-016 Accept condition in IDLE: core_val[core_cnt]=1, bank field of core core_cnt == BANK_ID, and core_cnt != last_id while skip_flag=1.
REQ-017 On accept (cycle T): latch id=core_cnt, word, we, wdata; load access counter with LATENCY-1; next state ACCESS.
REQ-018 IDLE with no accept: remain IDLE; core_serv stays 0.
REQ-019 ACCESS: counter decrements each cycle; in the cycle it reads 0, perform the write (if we) or capture mem[word] into the read register (if !we); next state RESP.
REQ-020 Writes update memory at the end of the last ACCESS cycle only; a read of the same word in a later request returns the new value.
REQ-021 RESP (cycle T+LATENCY+1): core_ack[id]=1 for exactly this cycle, all other bits 0; rd_data updated for reads, unchanged for writes; next state IDLE.
REQ-022 core_serv=1 in every cycle in ACCESS or RESP (T+1 through T+LATENCY+1 inclusive), 0 in IDLE.
REQ-023 Total latency accept to ack = LATENCY+1 cycles; back-to-back throughput one request per LATENCY+2 cycles.
REQ-024 On leaving RESP: set last_id=id, skip_flag=1; skip_flag clears after exactly one IDLE cycle, preventing re-acceptance of a core whose core_val drops one cycle after ack.
REQ-025 core_val, core_we, bank_addr, wr_data changes after accept shall not affect the latched request.
REQ-026 Requests whose bank field != BANK_ID are ignored entirely, including when selected by core_cnt.
REQ-027 core_cnt=15 and core_cnt=0 are handled identically to all other indices (no wrap special case in this block).

Reset
REQ-028 Reset value: state IDLE, core_serv=0, core_ack=16'h0, rd_data=16'h0, bank_num=BANK_ID, skip_flag=0, counter=0.
REQ-029 Reset asserted in ACCESS or RESP aborts the request: no ack, no write if reset is sampled at or before the write edge.
REQ-030 Reset takes priority over every other event in the same cycle.

Verification
REQ-031 Write then read: LATENCY=2, BANK_ID=3, core 5 writes 16'hBEEF to word 8'h10 (bank_addr[71:60]=12'h310), core_cnt=5 -> core_serv high 3 cycles, core_ack=16'h0020 at T+3; later read of same word -> rd_data=16'hBEEF with ack at T+3.
REQ-032 Bank mismatch: core_cnt=2, core_val[2]=1, bank field 4'h1, BANK_ID=3 -> no accept, core_serv=0, core_ack=0 indefinitely.
REQ-033 Skip rule: core 7 served, core_val[7] held high one cycle after ack with core_cnt=7 -> not re-accepted that cycle; accepted on a later cycle if still valid.
REQ-034 LATENCY=1 boundary: read accepted at T -> ack and rd_data at T+2; core_serv high at T+1, T+2 only.
REQ-035 Reset mid-write: reset during first ACCESS cycle of a write to word 8'h20 -> no ack; subsequent read of 8'h20 returns prior contents.
REQ-036 Stability: after accept, change core_we, wr_data, bank_addr of the served core -> completed access uses latched values only.
